dd_led_receiver: RTL and testbench

DD_LED_RECEIVER -- requirements
Module: dd_led_receiver

---
 rtl/dd_led_receiver.sv | 198 +++++++++++++++++++
 tb/tb_dd_led_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dd_led_receiver.sv
// dd_led_receiver: single-wire LED stream receiver.
// Recovers GRB words and packs 2-bit colour codes into an LED row.
module dd_led_receiver #(
    parameter int         N_LEDS           = 10,
    parameter logic [7:0] LED_BRIGHTNESS_0 = 8'h00,
    parameter logic [7:0] LED_BRIGHTNESS_1 = 8'h16,
    parameter logic [7:0] LED_BRIGHTNESS_2 = 8'h32,
    parameter logic [7:0] LED_BRIGHTNESS_3 = 8'h64,
    parameter int         CLK_FREQ         = 100,
    parameter int         TIME_RST         = 50000,
    parameter int         TIME_HMIN        = 150,
    parameter int         TIME_THR         = 600,
    parameter int         TIME_HMAX        = 1200
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      data_rx,
    output logic [23:0]               led_word,
    output logic [$clog2(N_LEDS):0]   led_idx,
    output logic                      word_valid,
    output logic [N_LEDS*6-1:0]       led_row,
    output logic                      row_valid,
    output logic                      frame_done,
    output logic [3:0]                err_flags
);

    localparam int RST_C  = TIME_RST * CLK_FREQ / 1000;
    localparam int HMIN_C = TIME_HMIN * CLK_FREQ / 1000;
    localparam int THR_C  = TIME_THR * CLK_FREQ / 1000;
    localparam int HMAX_C = TIME_HMAX * CLK_FREQ / 1000;
    localparam int CMAX   = (RST_C > HMAX_C) ? RST_C : HMAX_C;
    localparam int CW     = $clog2(CMAX + 2);
    localparam int IW     = $clog2(N_LEDS) + 1;

    localparam logic [CW-1:0] RST_V  = CW'(RST_C);
    localparam logic [CW-1:0] HMIN_V = CW'(HMIN_C);
    localparam logic [CW-1:0] THR_V  = CW'(THR_C);
    localparam logic [CW-1:0] HMAX_V = CW'(HMAX_C);

    localparam logic [1:0] S_WAIT_GAP = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_LOW      = 2'd3;

    logic [1:0]            sync_q;
    logic                  rx;
    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic [22:0]           shreg;
    logic [4:0]            bit_cnt;
    logic [IW-1:0]         word_cnt;
    logic                  any_bit;
    logic [N_LEDS*6-1:0]   staging;
    logic [23:0]           new_word;
    logic [2:0]            d2, d1, d0;
    logic [5:0]            code6;
    logic                  bad_byte;
    logic [3:0]            fin_err;

    // {match, code}; an unknown byte maps to code 00
    function automatic logic [2:0] dec_byte(input logic [7:0] b);
        logic [2:0] r;
        r = 3'b000;
        unique case (1'b1)
            (b == LED_BRIGHTNESS_0): r = 3'b100;
            (b == LED_BRIGHTNESS_1): r = 3'b101;
            (b == LED_BRIGHTNESS_2): r = 3'b110;
            (b == LED_BRIGHTNESS_3): r = 3'b111;
            default:                 r = 3'b000;
        endcase
        return r;
    endfunction

    assign rx       = sync_q[1];
    assign cnt_inc  = cnt + CW'(1);
    assign new_word = {shreg, (cnt >= THR_V)};

    always_comb begin
        d2       = dec_byte(new_word[23:16]);
        d1       = dec_byte(new_word[15:8]);
        d0       = dec_byte(new_word[7:0]);
        code6    = {d2[1:0], d1[1:0], d0[1:0]};
        bad_byte = !(d2[2] && d1[2] && d0[2]);
        fin_err  = {err_flags[3] | (word_cnt != IW'(N_LEDS)),
                    err_flags[2],
                    err_flags[1] | (bit_cnt != 5'd0),
                    err_flags[0]};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q     <= 2'b00;
            state      <= S_WAIT_GAP;
            cnt        <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            any_bit    <= 1'b0;
            staging    <= '0;
            led_word   <= '0;
            led_idx    <= '0;
            led_row    <= '0;
            err_flags  <= '0;
            word_valid <= 1'b0;
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], data_rx};
            word_valid <= 1'b0;
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_WAIT_GAP: begin
                    if (rx) begin
                        cnt <= '0;
                    end else if (cnt_inc >= RST_V) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_IDLE: begin
                    if (rx) begin
                        state     <= S_HIGH;
                        cnt       <= CW'(1);
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                        any_bit   <= 1'b0;
                        err_flags <= '0;
                    end
                end
                S_HIGH: begin
                    if (rx) begin
                        if (cnt >= HMAX_V) begin
                            err_flags[0] <= 1'b1;
                            state        <= S_WAIT_GAP;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        state <= S_LOW;
                        cnt   <= CW'(1);
                        if (cnt < HMIN_V) begin
                            err_flags[0] <= 1'b1;
                        end else begin
                            shreg   <= new_word[22:0];
                            any_bit <= 1'b1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt    <= '0;
                                word_valid <= 1'b1;
                                led_word   <= new_word;
                                led_idx    <= word_cnt;
                                if (word_cnt != {IW{1'b1}})
                                    word_cnt <= word_cnt + 1'b1;
                                if (word_cnt < IW'(N_LEDS)) begin
                                    for (int k = 0; k < N_LEDS; k++)
                                        if (word_cnt == IW'(k))
                                            staging[6*k +: 6] <= code6;
                                    if (bad_byte)
                                        err_flags[2] <= 1'b1;
                                end else begin
                                    err_flags[3] <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                S_LOW: begin
                    if (rx) begin
                        state <= S_HIGH;
                        cnt   <= CW'(1);
                    end else if (cnt_inc >= RST_V) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        // a gap after only rejected pulses is not a frame
                        if (any_bit) begin
                            frame_done <= 1'b1;
                            err_flags  <= fin_err;
                            if (fin_err == 4'd0) begin
                                led_row   <= staging;
                                row_valid <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= S_WAIT_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_dd_led_receiver.sv
// tb_dd_led_receiver: random frames against a pulse-list reference model.
// Timing runs at CLK_FREQ=20, i.e. every cycle count is one fifth of default.
module tb_dd_led_receiver;

    localparam int N    = 10;
    localparam int CF   = 20;
    localparam int RST  = 50000 * CF / 1000;
    localparam int HMIN = 150 * CF / 1000;
    localparam int THR  = 600 * CF / 1000;
    localparam int HMAX = 1200 * CF / 1000;
    localparam int IW   = $clog2(N) + 1;
    localparam int RW   = N * 6;

    logic            clock;
    logic            resetn;
    logic            data_rx;
    logic [23:0]     led_word;
    logic [IW-1:0]   led_idx;
    logic            word_valid;
    logic [RW-1:0]   led_row;
    logic            row_valid;
    logic            frame_done;
    logic [3:0]      err_flags;

    dd_led_receiver #(.N_LEDS(N), .CLK_FREQ(CF)) dut (
        .clock(clock), .resetn(resetn), .data_rx(data_rx),
        .led_word(led_word), .led_idx(led_idx), .word_valid(word_valid),
        .led_row(led_row), .row_valid(row_valid), .frame_done(frame_done),
        .err_flags(err_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nvec = 0;
    int nerr = 0;

    // observed strobes
    logic [23:0]   aw_q[$];
    int            ai_q[$];
    logic [3:0]    af_err[$];
    logic          af_rv[$];
    int            stray_rv = 0;

    always @(negedge clock) begin
        if (word_valid) begin
            aw_q.push_back(led_word);
            ai_q.push_back(int'(led_idx));
        end
        if (frame_done) begin
            af_err.push_back(err_flags);
            af_rv.push_back(row_valid);
        end
        if (row_valid && !frame_done) stray_rv++;
    end

    // pulse list and model expectations
    int            hq[$];
    logic [23:0]   ew_q[$];
    int            ei_q[$];
    int            e_fd;
    logic [3:0]    e_err;
    logic          e_rv;
    logic [RW-1:0] mdl_row;

    function automatic logic [7:0] bval(input int c);
        case (c)
            0: return 8'h00;
            1: return 8'h16;
            2: return 8'h32;
            default: return 8'h64;
        endcase
    endfunction

    function automatic int code_of(input logic [7:0] b);
        for (int c = 0; c < 4; c++)
            if (bval(c) == b) return c;
        return -1;
    endfunction

    function automatic logic [23:0] rand_word();
        return {bval($urandom_range(0, 3)), bval($urandom_range(0, 3)),
                bval($urandom_range(0, 3))};
    endfunction

    task automatic add_bit(input logic b, input bit fixed);
        if (fixed) hq.push_back(b ? 16 : 8);
        else hq.push_back(b ? int'($urandom_range(THR, HMAX))
                            : int'($urandom_range(HMIN, THR - 1)));
    endtask

    task automatic add_word(input logic [23:0] w, input bit fixed);
        for (int i = 23; i >= 0; i--) add_bit(w[i], fixed);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_pulses(input int from, input int to, input bit fixed);
        for (int i = from; i < to; i++) begin
            data_rx = 1'b1;
            cyc(hq[i]);
            data_rx = 1'b0;
            cyc(fixed ? 24 - hq[i] : int'($urandom_range(2, 8)));
        end
    endtask

    task automatic clear_mon();
        aw_q.delete(); ai_q.delete(); af_err.delete(); af_rv.delete();
        stray_rv = 0;
    endtask

    // Frame semantics straight from the pulse widths.
    task automatic model_frame();
        logic       bits[$];
        logic [23:0] w;
        logic [RW-1:0] row;
        int         nw, c;
        bit         aband;
        ew_q.delete(); ei_q.delete();
        e_err = 4'd0; aband = 0; row = '0;
        for (int i = 0; i < hq.size(); i++) begin
            if (hq[i] > HMAX) begin
                aband = 1; e_err[0] = 1'b1; break;
            end else if (hq[i] < HMIN) e_err[0] = 1'b1;
            else bits.push_back(hq[i] >= THR);
        end
        nw = bits.size() / 24;
        for (int k = 0; k < nw; k++) begin
            for (int j = 0; j < 24; j++) w[23 - j] = bits[24 * k + j];
            ew_q.push_back(w);
            ei_q.push_back(k > (1 << IW) - 1 ? (1 << IW) - 1 : k);
            if (k < N) begin
                for (int b = 0; b < 3; b++) begin
                    c = code_of(w[8 * b +: 8]);
                    if (c < 0) begin e_err[2] = 1'b1; c = 0; end
                    row[6 * k + 2 * b +: 2] = 2'(c);
                end
            end else e_err[3] = 1'b1;
        end
        if (aband) begin
            e_fd = 0; e_rv = 0;
        end else begin
            e_fd = (bits.size() > 0) ? 1 : 0;
            if (bits.size() % 24 != 0) e_err[1] = 1'b1;
            if (nw != N) e_err[3] = 1'b1;
            e_rv = (e_fd == 1) && (e_err == 4'd0);
            if (e_rv) mdl_row = row;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; data_rx = 1'b0;
        cyc(3);
        nvec++; if (led_word !== 24'd0) begin nerr++; $display("FAIL rst_word got %h want 0", led_word); end
        nvec++; if (led_idx !== '0) begin nerr++; $display("FAIL rst_idx got %0d want 0", led_idx); end
        nvec++; if (word_valid !== 1'b0) begin nerr++; $display("FAIL rst_wv got %b want 0", word_valid); end
        nvec++; if (led_row !== '0) begin nerr++; $display("FAIL rst_row got %h want 0", led_row); end
        nvec++; if (row_valid !== 1'b0) begin nerr++; $display("FAIL rst_rv got %b want 0", row_valid); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL rst_fd got %b want 0", frame_done); end
        nvec++; if (err_flags !== 4'd0) begin nerr++; $display("FAIL rst_err got %b want 0", err_flags); end
        resetn = 1'b1;
        mdl_row = '0;
        cyc(RST + 10);
    endtask

    task automatic test_basic();
        hq.delete(); clear_mon();
        for (int k = 0; k < N; k++) add_word(24'h643216, 1'b1);
        model_frame();
        send_pulses(0, hq.size(), 1'b1);
        cyc(RST + 10);
        nvec++; if (aw_q.size() != 10) begin nerr++; $display("FAIL basic_nwords got %0d want 10", aw_q.size()); end
        for (int i = 0; i < aw_q.size(); i++) begin
            nvec++;
            if (aw_q[i] !== 24'h643216 || ai_q[i] !== i) begin
                nerr++; $display("FAIL basic_word%0d got %h/%0d want 643216/%0d", i, aw_q[i], ai_q[i], i);
            end
        end
        nvec++; if (af_err.size() != 1) begin nerr++; $display("FAIL basic_fd got %0d want 1", af_err.size()); end
        else begin
            nvec++; if (af_err[0] !== 4'd0) begin nerr++; $display("FAIL basic_err got %b want 0000", af_err[0]); end
            nvec++; if (af_rv[0] !== 1'b1) begin nerr++; $display("FAIL basic_rv got %b want 1", af_rv[0]); end
        end
        nvec++; if (led_row !== {N{6'b111001}}) begin nerr++; $display("FAIL basic_row got %h want %h", led_row, {N{6'b111001}}); end
        nvec++; if (led_row !== mdl_row) begin nerr++; $display("FAIL basic_model_row got %h want %h", led_row, mdl_row); end
        nvec++; if (stray_rv !== 0) begin nerr++; $display("FAIL basic_stray got %0d want 0", stray_rv); end
    endtask

    task automatic test_frame(input string nm, input int nleds, input int short_at,
                              input int bad_at, input int extra_bits);
        logic [23:0] w;
        hq.delete(); clear_mon();
        for (int k = 0; k < nleds; k++) begin
            if (k == short_at) hq.push_back(HMIN - 1);
            w = rand_word();
            if (k == bad_at) w[15:8] = 8'h20;
            add_word(w, 1'b0);
        end
        for (int i = 0; i < extra_bits; i++) add_bit(1'($urandom_range(0, 1)), 1'b0);
        model_frame();
        send_pulses(0, hq.size(), 1'b0);
        cyc(RST + 10);
        nvec++; if (aw_q.size() != ew_q.size()) begin nerr++; $display("FAIL %s_nwords got %0d want %0d", nm, aw_q.size(), ew_q.size()); end
        for (int i = 0; i < aw_q.size() && i < ew_q.size(); i++) begin
            nvec++;
            if (aw_q[i] !== ew_q[i] || ai_q[i] !== ei_q[i]) begin
                nerr++; $display("FAIL %s_word%0d got %h/%0d want %h/%0d", nm, i, aw_q[i], ai_q[i], ew_q[i], ei_q[i]);
            end
        end
        nvec++; if (af_err.size() != e_fd) begin nerr++; $display("FAIL %s_fd got %0d want %0d", nm, af_err.size(), e_fd); end
        else if (e_fd == 1) begin
            nvec++; if (af_err[0] !== e_err) begin nerr++; $display("FAIL %s_err got %b want %b", nm, af_err[0], e_err); end
            nvec++; if (af_rv[0] !== e_rv) begin nerr++; $display("FAIL %s_rv got %b want %b", nm, af_rv[0], e_rv); end
        end
        nvec++; if (led_row !== mdl_row) begin nerr++; $display("FAIL %s_row got %h want %h", nm, led_row, mdl_row); end
        nvec++; if (stray_rv !== 0) begin nerr++; $display("FAIL %s_stray got %0d want 0", nm, stray_rv); end
    endtask

    task automatic test_long_high();
        hq.delete(); clear_mon();
        add_word(rand_word(), 1'b0);
        for (int i = 0; i < 6; i++) add_bit(1'($urandom_range(0, 1)), 1'b0);
        hq.push_back(HMAX + 16);
        model_frame();
        send_pulses(0, hq.size(), 1'b0);
        cyc(RST + 10);
        nvec++; if (aw_q.size() != 1 || aw_q.size() != ew_q.size()) begin nerr++; $display("FAIL long_nwords got %0d want 1", aw_q.size()); end
        else begin
            nvec++; if (aw_q[0] !== ew_q[0]) begin nerr++; $display("FAIL long_word got %h want %h", aw_q[0], ew_q[0]); end
        end
        nvec++; if (af_err.size() != 0) begin nerr++; $display("FAIL long_fd got %0d want 0", af_err.size()); end
        nvec++; if (err_flags !== e_err) begin nerr++; $display("FAIL long_err got %b want %b", err_flags, e_err); end
        nvec++; if (led_row !== mdl_row) begin nerr++; $display("FAIL long_row got %h want %h", led_row, mdl_row); end
        test_frame("after_long", N, -1, -1, 0);
    endtask

    task automatic test_reset_mid();
        hq.delete(); clear_mon();
        for (int k = 0; k < N; k++) add_word(rand_word(), 1'b0);
        send_pulses(0, 6 * 24, 1'b0);
        cyc(4);
        nvec++; if (aw_q.size() != 6) begin nerr++; $display("FAIL rmid_pre got %0d want 6", aw_q.size()); end
        #2 resetn = 1'b0;
        #13 resetn = 1'b1;
        clear_mon();
        mdl_row = '0;
        send_pulses(6 * 24, hq.size(), 1'b0);
        cyc(RST + 10);
        nvec++; if (aw_q.size() != 0) begin nerr++; $display("FAIL rmid_words got %0d want 0", aw_q.size()); end
        nvec++; if (af_err.size() != 0) begin nerr++; $display("FAIL rmid_fd got %0d want 0", af_err.size()); end
        nvec++; if (led_row !== '0) begin nerr++; $display("FAIL rmid_row got %h want 0", led_row); end
        nvec++; if (err_flags !== 4'd0) begin nerr++; $display("FAIL rmid_err got %b want 0000", err_flags); end
        test_frame("rmid_next", N, -1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame("short_bit", N, 5, -1, 0);
        test_long_high();
        test_frame("nine", 9, -1, -1, 0);
        test_frame("eleven", 11, -1, -1, 0);
        test_frame("bad_byte", N, -1, 3, 0);
        test_frame("partial", 1, -1, -1, 6);
        test_reset_mid();
        test_frame("random", N, -1, -1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
